mem_copy_initiator: RTL and testbench

- Bus-master engine that drives the data-memory port (CLK, WE, a, WD, Rd) from the initiator side.
- Copies a block of 32-bit words from a source byte address to a destination byte address using word-aligned accesses.
- Sits beside the datapath. The top-level mux grants it the data-memory port while busy is high.
- Memory read is combinational (Rd valid in the same cycle as a). Memory write commits on the CLK rising edge when WE=1.

---
 rtl/mem_copy_initiator_if.sv | 43 ++++
 rtl/mem_copy_initiator.sv | 176 +++++++++++++++++
 tb/tb_mem_copy_initiator.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_initiator_if.sv
// Bus bundle for mem_copy_initiator: request/status handshake plus the
// data-memory port (WE, a, WD, Rd).
// Optional fill signals exist only when MEM_COPY_FILL_EN is defined.
interface mem_copy_initiator_if #(
    parameter int LEN_W  = 7,
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] src_addr;
    logic [DATA_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
`ifdef MEM_COPY_FILL_EN
    logic              fill_mode;
    logic [DATA_W-1:0] fill_value;
`endif
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

`ifdef MEM_COPY_FILL_EN
    modport master (
        input  start, src_addr, dst_addr, len, fill_mode, fill_value, mem_rd,
        output busy, done, err, mem_we, mem_a, mem_wd
    );
    modport slave (
        output start, src_addr, dst_addr, len, fill_mode, fill_value, mem_rd,
        input  busy, done, err, mem_we, mem_a, mem_wd
    );
`else
    modport master (
        input  start, src_addr, dst_addr, len, mem_rd,
        output busy, done, err, mem_we, mem_a, mem_wd
    );
    modport slave (
        output start, src_addr, dst_addr, len, mem_rd,
        input  busy, done, err, mem_we, mem_a, mem_wd
    );
`endif
endinterface

// File: rtl/mem_copy_initiator.sv
// mem_copy_initiator: bus-master engine copying a block of 32-bit words from
// a source byte address to a destination byte address, strictly ascending,
// two cycles per word (READ then WRITE) against a combinational-read memory.
// Optional macro MEM_COPY_FILL_EN adds a fill mode that writes a latched
// constant to the destination at one word per cycle.
// mem_a / mem_wd / mem_we are registers so the memory port is glitch-free.
module mem_copy_initiator #(
    parameter int LEN_W  = 7,
    parameter int DATA_W = 32
) (
    input logic                  CLK,
    input logic                  RST,
    mem_copy_initiator_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        WRITE,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  idx_inc;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              fill_on;
    logic              misaligned;
    logic [DATA_W-1:0] fill_word;

`ifdef MEM_COPY_FILL_EN
    logic              fill_q, fill_d;
    logic [DATA_W-1:0] fval_q, fval_d;
`endif

    // Byte offset of word index idx (4*idx), zero-extended to address width.
    function automatic logic [DATA_W-1:0] word_off(input logic [LEN_W-1:0] idx);
        return {{(DATA_W-LEN_W-2){1'b0}}, idx, 2'b00};
    endfunction

    // Register all FSM state, latched operands and memory-port outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_COPY_FILL_EN
            fill_q  <= 1'b0;
            fval_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            err_q   <= err_d;
`ifdef MEM_COPY_FILL_EN
            fill_q  <= fill_d;
            fval_q  <= fval_d;
`endif
        end
    end

    // Next-state, operand latching and next memory-port values.
    // The port registers are loaded on the edge entering READ/WRITE so they
    // are already valid for the whole cycle of that state.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        err_d   = err_q;
        idx_inc = idx_q + LEN_W'(1);
`ifdef MEM_COPY_FILL_EN
        fill_d    = fill_q;
        fval_d    = fval_q;
        fill_on   = fill_q;
        fill_word = fval_q;
`else
        fill_on   = 1'b0;
        fill_word = '0;
`endif
        // In fill mode the source address is unused, so its alignment is too.
        misaligned = (dst_q[1:0] != 2'b00) || (!fill_on && (src_q[1:0] != 2'b00));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d   = bus.src_addr;
                    dst_d   = bus.dst_addr;
                    len_d   = bus.len;
                    idx_d   = '0;
                    err_d   = 1'b0;
`ifdef MEM_COPY_FILL_EN
                    fill_d  = bus.fill_mode;
                    fval_d  = bus.fill_value;
`endif
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (misaligned) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (len_q == '0) begin
                    state_d = FIN;
                end else if (fill_on) begin
                    addr_d  = dst_q;
                    data_d  = fill_word;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end else begin
                    addr_d  = src_q;
                    state_d = READ;
                end
            end
            READ: begin
                addr_d  = dst_q + word_off(idx_q);
                data_d  = bus.mem_rd;
                we_d    = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d = idx_inc;
                if (idx_inc == len_q) begin
                    state_d = FIN;
                end else if (fill_on) begin
                    addr_d  = dst_q + word_off(idx_inc);
                    we_d    = 1'b1;
                    state_d = WRITE;
                end else begin
                    addr_d  = src_q + word_off(idx_inc);
                    state_d = READ;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status and memory-port outputs, decoded from registered state only.
    always_comb begin
        bus.busy   = (state_q == CHECK) || (state_q == READ) || (state_q == WRITE);
        bus.done   = (state_q == FIN);
        bus.err    = err_q;
        bus.mem_we = we_q;
        bus.mem_a  = addr_q;
        bus.mem_wd = data_q;
    end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Self-checking bench for mem_copy_initiator: a 64-word combinational-read
// memory, a word-level reference model of copy/fill, directed scenarios and
// randomized copies.
module tb_mem_copy_initiator;
    localparam int LEN_W  = 7;
    localparam int DATA_W = 32;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

`ifdef MEM_COPY_FILL_EN
    logic        fill_sel = 1'b0;
    logic [31:0] fill_val = '0;
`endif

    mem_copy_initiator_if #(.LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    mem_copy_initiator #(.LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    // Memory: combinational read, write committed at the rising edge.
    assign bus.mem_rd = mem[bus.mem_a[7:2]];
    always @(posedge CLK) begin
        if (bus.mem_we) mem[bus.mem_a[7:2]] = bus.mem_wd;
    end

    // Reference model: word-by-word ascending copy or fill on the 64-word array.
    function automatic bit model_err(input logic [31:0] s, input logic [31:0] d, input bit fm);
        return (d[1:0] != 2'b00) || (!fm && (s[1:0] != 2'b00));
    endfunction

    function automatic void model_op(input logic [31:0] s, input logic [31:0] d,
                                     input int n, input bit fm, input logic [31:0] fv);
        if (model_err(s, d, fm) || n == 0) return;
        for (int k = 0; k < n; k++) begin
            ref_mem[((d >> 2) + k) % 64] = fm ? fv : ref_mem[((s >> 2) + k) % 64];
        end
    endfunction

    function automatic int model_cycles(input logic [31:0] s, input logic [31:0] d,
                                        input int n, input bit fm);
        if (model_err(s, d, fm) || n == 0) return 2;
        return fm ? n + 2 : 2 * n + 2;
    endfunction

    function automatic int mem_diff();
        int bad = 0;
        for (int k = 0; k < 64; k++) if (mem[k] !== ref_mem[k]) bad++;
        return bad;
    endfunction

    task automatic init_mem();
        for (int k = 0; k < 64; k++) begin
            mem[k]     = $urandom;
            ref_mem[k] = mem[k];
        end
    endtask

    // Issue one start, then count cycles (edges after the start edge) to done
    // and cycles with mem_we high. Operand inputs are scrambled after the
    // start edge; start is re-raised with scrambled operands at cycle glitch_at.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int glitch_at, output int cyc, output int wes);
        @(negedge CLK);
        bus.start    = 1'b1;
        bus.src_addr = s;
        bus.dst_addr = d;
        bus.len      = 7'(n);
`ifdef MEM_COPY_FILL_EN
        bus.fill_mode  = fill_sel;
        bus.fill_value = fill_val;
`endif
        @(posedge CLK);
        #1;
        bus.start    = 1'b0;
        bus.src_addr = $urandom;
        bus.dst_addr = $urandom;
        bus.len      = 7'($urandom);
`ifdef MEM_COPY_FILL_EN
        bus.fill_mode  = 1'($urandom);
        bus.fill_value = $urandom;
`endif
        cyc = 0;
        wes = 0;
        while (cyc < 400) begin
            @(negedge CLK);
            cyc++;
            if (bus.mem_we) wes++;
            bus.start = (cyc == glitch_at);
            if (bus.done) break;
        end
        if (!bus.done) cyc = -1;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        bus.start = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.len      = '0;
`ifdef MEM_COPY_FILL_EN
        bus.fill_mode  = 1'b0;
        bus.fill_value = '0;
`endif
        init_mem();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL reset_a got=%h exp=0", bus.mem_a); end
        checks++; if (bus.mem_wd !== 32'h0) begin errors++; $display("FAIL reset_wd got=%h exp=0", bus.mem_wd); end
        RST = 1'b0;
    endtask

    task automatic test_aligned_copy();
        int cyc, wes;
        for (int k = 0; k < 4; k++) begin
            mem[k]     = 32'h11 * (k + 1);
            ref_mem[k] = mem[k];
        end
        run_copy(32'h0, 32'h40, 4, 0, cyc, wes);
        model_op(32'h0, 32'h40, 4, 1'b0, 32'h0);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL aligned_cycles got=%0d exp=10", cyc); end
        checks++; if (wes !== 4) begin errors++; $display("FAIL aligned_writes got=%0d exp=4", wes); end
        checks++; if (mem[19] !== 32'h44) begin errors++; $display("FAIL aligned_word19 got=%h exp=44", mem[19]); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL aligned_mem got=%0d bad words exp=0", mem_diff()); end
        @(negedge CLK);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL aligned_done_width got=%b exp=0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL aligned_idle_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.mem_a !== 32'h4C) begin errors++; $display("FAIL aligned_a_hold got=%h exp=4c", bus.mem_a); end
    endtask

    task automatic test_zero_len();
        int cyc, wes;
        run_copy(32'h0, 32'h20, 0, 0, cyc, wes);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL zero_cycles got=%0d exp=2", cyc); end
        checks++; if (wes !== 0) begin errors++; $display("FAIL zero_writes got=%0d exp=0", wes); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL zero_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_misaligned();
        int cyc, wes;
        run_copy(32'h2, 32'h40, 3, 0, cyc, wes);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL misal_cycles got=%0d exp=2", cyc); end
        checks++; if (wes !== 0) begin errors++; $display("FAIL misal_writes got=%0d exp=0", wes); end
        repeat (3) @(negedge CLK);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL misal_err_sticky got=%b exp=1", bus.err); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL misal_mem got=%0d bad words exp=0", mem_diff()); end
        run_copy(32'h0, 32'h41, 2, 0, cyc, wes);
        checks++; if (bus.err !== 1'b1 || wes !== 0) begin errors++; $display("FAIL misal_dst got err=%b writes=%0d exp err=1 writes=0", bus.err, wes); end
        run_copy(32'h8, 32'h80, 1, 0, cyc, wes);
        model_op(32'h8, 32'h80, 1, 1'b0, 32'h0);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL misal_clear got=%b exp=0", bus.err); end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL misal_next_cycles got=%0d exp=4", cyc); end
    endtask

    task automatic test_overlap();
        int cyc, wes;
        for (int k = 0; k < 4; k++) begin
            mem[k]     = 32'hA0 + k;
            ref_mem[k] = mem[k];
        end
        run_copy(32'h0, 32'h4, 3, 0, cyc, wes);
        model_op(32'h0, 32'h4, 3, 1'b0, 32'h0);
        checks++; if (mem[1] !== 32'hA0 || mem[2] !== 32'hA0 || mem[3] !== 32'hA0) begin
            errors++; $display("FAIL overlap_fwd got=%h,%h,%h exp=a0,a0,a0", mem[1], mem[2], mem[3]);
        end
        // Backward-overlapping move (dst < src) must be a correct move.
        run_copy(32'h24, 32'h20, 6, 0, cyc, wes);
        model_op(32'h24, 32'h20, 6, 1'b0, 32'h0);
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL overlap_mem got=%0d bad words exp=0", mem_diff()); end
    endtask

    task automatic test_random_copies();
        int cyc, wes, n;
        logic [31:0] s, d;
        for (int t = 0; t < 20; t++) begin
            s = 32'($urandom_range(0, 63)) << 2;
            d = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
            n = $urandom_range(0, 24);
            run_copy(s, d, n, 0, cyc, wes);
            model_op(s, d, n, 1'b0, 32'h0);
            checks++; if (cyc !== model_cycles(s, d, n, 1'b0)) begin
                errors++; $display("FAIL rand_cycles[%0d] got=%0d exp=%0d", t, cyc, model_cycles(s, d, n, 1'b0));
            end
            checks++; if (bus.err !== model_err(s, d, 1'b0)) begin
                errors++; $display("FAIL rand_err[%0d] got=%b exp=%b", t, bus.err, model_err(s, d, 1'b0));
            end
            checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL rand_mem[%0d] got=%0d bad words exp=0", t, mem_diff()); end
        end
    endtask

    task automatic test_start_ignored();
        int cyc, wes;
        // start raised mid-transfer with scrambled operands
        run_copy(32'h10, 32'hC0, 5, 3, cyc, wes);
        model_op(32'h10, 32'hC0, 5, 1'b0, 32'h0);
        checks++; if (cyc !== 12 || wes !== 5) begin errors++; $display("FAIL busy_start got cyc=%0d writes=%0d exp 12/5", cyc, wes); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL busy_start_mem got=%0d bad words exp=0", mem_diff()); end
        // start raised in the done cycle
        run_copy(32'h0, 32'h60, 2, 6, cyc, wes);
        model_op(32'h0, 32'h60, 2, 1'b0, 32'h0);
        wes = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (bus.busy || bus.mem_we || bus.done) wes++;
        end
        checks++; if (wes !== 0) begin errors++; $display("FAIL fin_start got=%0d active cycles exp=0", wes); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL fin_start_mem got=%0d bad words exp=0", mem_diff()); end
    endtask

    task automatic test_max_len();
        int cyc, wes;
        init_mem();
        run_copy(32'h0, 32'h40, 127, 0, cyc, wes);
        model_op(32'h0, 32'h40, 127, 1'b0, 32'h0);
        checks++; if (cyc !== 256 || wes !== 127) begin errors++; $display("FAIL max_len got cyc=%0d writes=%0d exp 256/127", cyc, wes); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL max_len_mem got=%0d bad words exp=0", mem_diff()); end
    endtask

    task automatic test_reset_mid();
        int active = 0;
        init_mem();
        @(negedge CLK);
        bus.start    = 1'b1;
        bus.src_addr = 32'h0;
        bus.dst_addr = 32'h40;
        bus.len      = 7'd4;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        // cycles: 1 CHECK, 2 READ, 3 WRITE, 4 READ; reset sampled at the edge
        // that would enter the second WRITE, cancelling it.
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        ref_mem[16] = ref_mem[0];
        @(negedge CLK);
        checks++; if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out got busy=%b we=%b exp 0/0", bus.busy, bus.mem_we);
        end
        checks++; if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL rst_mid_a got=%h exp=0", bus.mem_a); end
        for (int k = 0; k < 12; k++) begin
            if (bus.done || bus.mem_we || bus.busy) active++;
            @(negedge CLK);
        end
        checks++; if (active !== 0) begin errors++; $display("FAIL rst_mid_quiet got=%0d active cycles exp=0", active); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL rst_mid_mem got=%0d bad words exp=0", mem_diff()); end
    endtask

`ifdef MEM_COPY_FILL_EN
    task automatic test_fill();
        int cyc, wes;
        fill_sel = 1'b1;
        fill_val = 32'hDEADBEEF;
        run_copy(32'h3, 32'h80, 5, 0, cyc, wes);
        model_op(32'h3, 32'h80, 5, 1'b1, 32'hDEADBEEF);
        checks++; if (cyc !== 7 || wes !== 5) begin errors++; $display("FAIL fill got cyc=%0d writes=%0d exp 7/5", cyc, wes); end
        checks++; if (mem[36] !== 32'hDEADBEEF || bus.err !== 1'b0) begin
            errors++; $display("FAIL fill_word36 got=%h err=%b exp=deadbeef err=0", mem[36], bus.err);
        end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL fill_mem got=%0d bad words exp=0", mem_diff()); end
        fill_val = $urandom;
        run_copy(32'h0, 32'h82, 3, 0, cyc, wes);
        checks++; if (bus.err !== 1'b1 || wes !== 0 || cyc !== 2) begin
            errors++; $display("FAIL fill_misal got err=%b writes=%0d cyc=%0d exp 1/0/2", bus.err, wes, cyc);
        end
        fill_sel = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_aligned_copy();
        test_zero_len();
        test_misaligned();
        test_overlap();
        test_random_copies();
        test_start_ignored();
        test_max_len();
        test_reset_mid();
`ifdef MEM_COPY_FILL_EN
        test_fill();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
